// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter and the receiver.
//   UART_DATA_BITS  - payload bits per frame
//   UART_IDX_W      - width of the data bit index
//   uart_state_e    - frame state encoding (IDLE=0 .. STOP=4, 3 bits)
//   uart_even_parity- even parity over one payload byte
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);
  localparam int unsigned UART_STATE_W   = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter for the UART transmitter.
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset, clears the count
//   clear    - holds the count at zero (used while the line is idle)
//   tick     - high on the last cycle of a bit period (count CLKS_PER_BIT-1)
//   pre_tick - high one cycle before tick (count CLKS_PER_BIT-2)
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_count;

  // Counts 0..CLKS_PER_BIT-1 and wraps, so consecutive bits need no restart.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tick     = (r_count == CNT_W'(CLKS_PER_BIT - 1));
  // Look-ahead lets done/ready be registered yet line up with the final stop cycle.
  assign pre_tick = (r_count == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN defined).
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset; aborts any frame in progress
//   dataIn - byte to transmit, sampled only on an accepted send
//   send   - request strobe, accepted when send=1 and ready=1 at a rising edge
//   ready  - high when a send will be accepted
//   done   - one-cycle pulse on the final cycle of the stop bit
//   txOut  - serial line, idle high, LSB first
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after the data.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] dataIn,
  input  logic                      send,
  output logic                      ready,
  output logic                      done,
  output logic                      txOut
);

  uart_state_e               r_state;
  uart_state_e               w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic [UART_IDX_W-1:0]     r_idx;
  logic [UART_IDX_W-1:0]     w_idx_next;
  logic                      r_tx;
  logic                      r_ready;
  logic                      r_done;
  logic                      w_tx_next;
  logic                      w_ready_next;
  logic                      w_done_next;
  logic                      w_tick;
  logic                      w_pre_tick;
  logic                      w_accept;
  logic                      w_clear;
  logic                      w_last_bit;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  assign w_accept   = send && r_ready;
  assign w_clear    = (r_state == ST_IDLE);
  assign w_last_bit = (r_idx == UART_IDX_W'(UART_DATA_BITS - 1));

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .tick    (w_tick),
    .pre_tick(w_pre_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a send on the last stop cycle chains straight into START.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_START;
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_tick) w_state_next = w_accept ? ST_START : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered line, done and ready.
  always_comb begin
    w_tx_next    = 1'b1;
    w_done_next  = 1'b0;
    w_ready_next = 1'b0;
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_next = r_parity;
`endif
      default:   w_tx_next = 1'b1;
    endcase
    w_done_next  = (r_state == ST_STOP) && w_pre_tick;
    w_ready_next = (w_state_next == ST_IDLE) || w_done_next;
  end

  // Shift register and bit index: load on accept, shift at the end of each data bit.
  always_comb begin
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    if (w_accept) begin
      w_shift_next = dataIn;
      w_idx_next   = '0;
    end else if ((r_state == ST_DATA) && w_tick) begin
      w_shift_next = {1'b0, r_shift[UART_DATA_BITS-1:1]};
      w_idx_next   = r_idx + UART_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity taken from the byte as accepted; later dataIn changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= uart_even_parity(dataIn);
    end
  end
`endif

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx_next;
      r_ready <= w_ready_next;
      r_done  <= w_done_next;
    end
  end

  assign txOut = r_tx;
  assign ready = r_ready;
  assign done  = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed self-checking bench for uart_transmitter at CLKS_PER_BIT=4.
// Honours UART_TX_PARITY_EN (11-bit frames with an even-parity bit when defined).
module tb_uart_transmitter;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
  localparam bit          PAR_EN     = 1'b1;
`else
  localparam int unsigned FRAME_BITS = 10;
  localparam bit          PAR_EN     = 1'b0;
`endif
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] dataIn;
  logic       ready;
  logic       done;
  logic       txOut;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dataIn(dataIn),
    .send  (send),
    .ready (ready),
    .done  (done),
    .txOut (txOut)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected line level on cycle k (1-based) after the accepting edge.
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR_EN && (b == 9)) return ^d;
    return 1'b1;
  endfunction

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle tx", tag), 32'(txOut), 32'd1);
      check($sformatf("%s idle ready", tag), 32'(ready), 32'd1);
      check($sformatf("%s idle done", tag), 32'(done), 32'd0);
    end
  endtask

  // Present a byte with send=1 and return right after the accepting edge.
  task automatic start_frame(input string tag, input logic [7:0] d);
    @(negedge clk);
    check($sformatf("%s ready before send", tag), 32'(ready), 32'd1);
    dataIn = d;
    send   = 1'b1;
    @(posedge clk);
  endtask

  // Check every cycle of a frame. chain: hold send with nxt for a back-to-back frame;
  // pulse_k: pulse send with other data on that cycle; abort_k: raise reset on that cycle.
  task automatic check_frame(input string tag, input logic [7:0] d, input bit chain,
                             input logic [7:0] nxt, input int pulse_k, input int abort_k);
    for (int k = 1; k <= int'(FRAME_CYC); k++) begin
      @(negedge clk);
      check($sformatf("%s tx k=%0d", tag, k), 32'(txOut), 32'(exp_tx(d, k)));
      check($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(k == int'(FRAME_CYC)));
      check($sformatf("%s ready k=%0d", tag, k), 32'(ready), 32'(k == int'(FRAME_CYC)));
      if (k == abort_k) begin
        reset = 1'b1;
        send  = 1'b0;
        return;
      end
      if (chain) begin
        send   = 1'b1;
        dataIn = nxt;
      end else if (k == pulse_k) begin
        send   = 1'b1;
        dataIn = ~d;
      end else begin
        send   = 1'b0;
        dataIn = 8'($urandom);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    send   = 1'b0;
    dataIn = 8'h00;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(txOut), 32'd1);
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    idle_cycles("post reset", 2);

    // Alternating pattern: line toggles every bit, done on cycle FRAME_CYC.
    start_frame("f55", 8'h55);
    check_frame("f55", 8'h55, 1'b0, 8'h00, 0, 0);
    idle_cycles("f55", 3);

    // Odd and even ones-count bytes (parity 1 and 0 when parity is built in).
    start_frame("f07", 8'h07);
    check_frame("f07", 8'h07, 1'b0, 8'h00, 0, 0);
    idle_cycles("f07", 2);
    start_frame("f03", 8'h03);
    check_frame("f03", 8'h03, 1'b0, 8'h00, 0, 0);
    idle_cycles("f03", 2);

    // Send held high: second start bit follows done with no idle bit.
    start_frame("fA5", 8'hA5);
    check_frame("fA5", 8'hA5, 1'b1, 8'h3C, 0, 0);
    check_frame("f3C", 8'h3C, 1'b0, 8'h00, 0, 0);
    idle_cycles("f3C", 3);

    // Send pulsed mid-frame with different data is ignored.
    start_frame("fC3", 8'hC3);
    check_frame("fC3", 8'hC3, 1'b0, 8'h00, 10, 0);
    idle_cycles("fC3", 6);

    // Reset during data bit 3 aborts the frame without a done pulse.
    start_frame("f96", 8'h96);
    check_frame("f96", 8'h96, 1'b0, 8'h00, 0, 18);
    @(negedge clk);
    check("abort tx", 32'(txOut), 32'd1);
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    reset = 1'b0;
    idle_cycles("after abort", int'(FRAME_CYC));
    start_frame("fFF", 8'hFF);
    check_frame("fFF", 8'hFF, 1'b0, 8'h00, 0, 0);
    idle_cycles("fFF", 2);

    // Reset has priority over a simultaneous send.
    @(negedge clk);
    reset  = 1'b1;
    send   = 1'b1;
    dataIn = 8'h5A;
    @(negedge clk);
    check("rst+send tx", 32'(txOut), 32'd1);
    check("rst+send ready", 32'(ready), 32'd1);
    check("rst+send done", 32'(done), 32'd0);
    reset = 1'b0;
    send  = 1'b0;
    idle_cycles("rst+send", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208 (50 MHz / 9600 baud), clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dataIn  input  8  byte to transmit, sampled only on an accepted send.
REQ-005 SHALL have port send  input  1  request strobe; a transfer is accepted when send=1 and ready=1 at a rising edge.
REQ-006 SHALL have port ready  output  1  high when idle and able to accept send.
REQ-007 SHALL have port done  output  1  one-cycle pulse on the final cycle of the stop bit.
REQ-008 SHALL have port txOut  output  1  serial line; idle level 1.

Function
REQ-009 SHALL implement states IDLE, START, DATA, PARITY (only when enabled), STOP.
REQ-010 SHALL move IDLE->START on an accepted send, latching dataIn into an internal shift register.
REQ-011 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by a bit counter of width $clog2(CLKS_PER_BIT).
REQ-012 SHALL drive txOut from a register: 0 in START, data LSB first in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-013 SHALL drive txOut low on the first cycle after the accepting edge (latency one cycle).
REQ-014 SHALL count 8 data bits with a 3-bit index; DATA->PARITY (or ->STOP) after index 7 completes its bit time.
REQ-015 SHALL assert ready only in IDLE; ready rises in the same cycle done pulses, so that a send in that cycle starts the next frame with no idle bit between frames.
REQ-016 SHALL ignore send while ready=0; dataIn changes during a frame SHALL NOT affect the frame in progress.
REQ-017 SHALL produce a 10-bit frame without parity and an 11-bit frame with parity, i.e. 10*CLKS_PER_BIT or 11*CLKS_PER_BIT cycles from txOut falling to the end of stop.

Reset
REQ-018 SHALL, while reset=1, force state IDLE, txOut=1, ready=1, done=0 and clear the counters and shift register at the next rising edge.
REQ-019 SHALL abort a frame when reset is asserted mid-frame, with txOut returning to 1 at the next edge and no done pulse.
REQ-020 SHALL give reset priority over send when both are high.

Configuration
REQ-021 SHALL compile the PARITY state and an even-parity bit (XOR of the 8 latched data bits) only when macro UART_TX_PARITY_EN is defined.
REQ-022 SHALL, without UART_TX_PARITY_EN, go DATA->STOP directly and contain no parity logic.

Structure
REQ-023 SHALL take the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits) and UART_DATA_BITS=8 from shared package uart_pkg, which is also used by the receiver.
REQ-024 SHALL place bit timing in sub-module uart_bit_timer (inputs clk, reset, clear; output tick at count CLKS_PER_BIT-1); the FSM and shift register stay in uart_transmitter.

Verification (CLKS_PER_BIT=4)
REQ-025 SHALL check: send with dataIn=0x55 -> txOut = 0,1,0,1,0,1,0,1,0,1 for 4 cycles each, done high on cycle 40 after the accepting edge.
REQ-026 SHALL check: with UART_TX_PARITY_EN, dataIn=0x07 -> parity bit 1, frame 44 cycles; dataIn=0x03 -> parity bit 0.
REQ-027 SHALL check: send held high continuously with 0xA5 then 0x3C -> second start bit begins the cycle after done; no extra idle bit.
REQ-028 SHALL check: send pulsed mid-frame with a different dataIn -> ignored; the frame in progress is unchanged.
REQ-029 SHALL check: reset asserted during DATA bit 3 -> next edge txOut=1, ready=1, no done; a following send of 0xFF transmits correctly.
REQ-030 SHALL check: reset and send high in the same cycle -> remains IDLE, txOut=1.
